seq_alu: RTL and testbench

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 191 +++++++++++++++++++
 tb/tb_seq_alu.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/seq_alu.sv
// seq_alu: sequential ALU with 1-cycle ops, shift-add multiply and, when SEQ_ALU_DIV_EN is defined, a restoring divider
module seq_alu #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] result_hi,
  output logic                  busy
);
  localparam int W = DATA_WIDTH;
  localparam int SHAMT_W = $clog2(W);
`ifdef SEQ_ALU_DIV_EN
  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, MUL, FIX, DONE} state_t;
`endif
  state_t state_q, state_d;
  logic out_valid_q, out_valid_d, neg_q, neg_d;
  logic [W-1:0] result_q, result_d, result_hi_q, result_hi_d, opnd_q, opnd_d;
  logic [2*W-1:0] acc_q, acc_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic accept, is_mul, sa, sb;
  logic [W-1:0] abs_a, abs_b, alu, alu_hi;
  logic [SHAMT_W-1:0] shamt;
  logic [W:0] mul_sum;
  logic [2*W-1:0] mul_nxt, fix_val;
  assign in_ready = state_q == IDLE && (!out_valid_q || out_ready) && !flush;
  assign accept = in_valid && in_ready;
  assign is_mul = op[4:1] == 4'b0110;
  assign sa = a[W-1] && !op[0];
  assign sb = b[W-1] && !op[0];
  assign abs_a = sa ? -a : a;
  assign abs_b = sb ? -b : b;
  assign shamt = a[SHAMT_W-1:0];
  assign mul_sum = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_nxt = {mul_sum, acc_q[W-1:1]};
`ifdef SEQ_ALU_DIV_EN
  logic div0, is_div, ge, rneg_q, rneg_d, div_q, div_d;
  logic [W:0] div_r, div_diff;
  logic [2*W-1:0] div_nxt;
  assign div0 = op[4:1] == 4'b0111 && b == '0;
  assign is_div = op[4:1] == 4'b0111 && !div0;
  assign div_r = {acc_q[2*W-1:W], acc_q[W-1]};
  assign div_diff = div_r - {1'b0, opnd_q};
  assign ge = !div_diff[W];
  assign div_nxt = {ge ? div_diff[W-1:0] : div_r[W-1:0], acc_q[W-2:0], ge};
  assign alu_hi = div0 ? a : '0;
  assign fix_val = div_q ? {rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W], neg_q ? -acc_q[W-1:0] : acc_q[W-1:0]}
                         : (neg_q ? -acc_q : acc_q);
`else
  assign alu_hi = '0;
  assign fix_val = neg_q ? -acc_q : acc_q;
`endif
  assign out_valid = out_valid_q;
  assign result = result_q;
  assign result_hi = result_hi_q;
  assign busy = state_q != IDLE;
  // single-cycle datapath; multiply/divide and illegal codes fall to all ones
  always_comb begin
    alu = '1;
    case (op)
      5'd0:  alu = a + b;
      5'd1:  alu = a - b;
      5'd2:  alu = {{(W-1){1'b0}}, $signed(a) < $signed(b)};
      5'd3:  alu = {{(W-1){1'b0}}, a < b};
      5'd4:  alu = a & b;
      5'd5:  alu = ~(a | b);
      5'd6:  alu = a | b;
      5'd7:  alu = a ^ b;
      5'd8:  alu = b << shamt;
      5'd9:  alu = b >> shamt;
      5'd10: alu = $unsigned($signed(b) >>> shamt);
      5'd11: alu = {b[W/2-1:0], {(W/2){1'b0}}};
      default: alu = '1;
    endcase
  end
  // FSM next state, iteration datapath and result register; flush overrides everything
  always_comb begin
    state_d = state_q;
    out_valid_d = out_valid_q;
    result_d = result_q;
    result_hi_d = result_hi_q;
    opnd_d = opnd_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    neg_d = neg_q;
`ifdef SEQ_ALU_DIV_EN
    rneg_d = rneg_q;
    div_d = div_q;
`endif
    if (flush) begin
      state_d = IDLE;
      out_valid_d = 1'b0;
      cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && is_mul) begin
            state_d = MUL;
            out_valid_d = 1'b0;
            opnd_d = abs_a;
            acc_d = {{W{1'b0}}, abs_b};
            neg_d = sa ^ sb;
            cnt_d = '0;
`ifdef SEQ_ALU_DIV_EN
            div_d = 1'b0;
          end else if (accept && is_div) begin
            state_d = DIV;
            out_valid_d = 1'b0;
            opnd_d = abs_b;
            acc_d = {{W{1'b0}}, abs_a};
            neg_d = sa ^ sb;
            rneg_d = sa;
            div_d = 1'b1;
            cnt_d = '0;
`endif
          end else if (accept) begin
            out_valid_d = 1'b1;
            result_d = alu;
            result_hi_d = alu_hi;
          end else if (out_ready) begin
            out_valid_d = 1'b0;
          end
        end
        MUL: begin
          acc_d = mul_nxt;
          cnt_d = cnt_q + 1'b1;
          state_d = &cnt_q ? FIX : MUL;
        end
`ifdef SEQ_ALU_DIV_EN
        DIV: begin
          acc_d = div_nxt;
          cnt_d = cnt_q + 1'b1;
          state_d = &cnt_q ? FIX : DIV;
        end
`endif
        FIX: begin
          state_d = DONE;
          out_valid_d = 1'b1;
          {result_hi_d, result_d} = fix_val;
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
            out_valid_d = 1'b0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
  // state register with asynchronous active-low reset
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      out_valid_q <= 1'b0;
      result_q <= '0;
      result_hi_q <= '0;
      opnd_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      neg_q <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      rneg_q <= 1'b0;
      div_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      out_valid_q <= out_valid_d;
      result_q <= result_d;
      result_hi_q <= result_hi_d;
      opnd_q <= opnd_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      neg_q <= neg_d;
`ifdef SEQ_ALU_DIV_EN
      rneg_q <= rneg_d;
      div_q <= div_d;
`endif
    end
  end
endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu: directed vector table plus hand sequences for back-to-back, backpressure, flush and reset
module tb_seq_alu;
  localparam int W = 32;
  logic clk = 1'b0, resetn = 1'b0, in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, busy;
  logic [4:0] op = '0;
  logic [W-1:0] a = '0, b = '0, result, result_hi;
  int tests = 0, fails = 0, cyc = 0;
  typedef struct packed {
    logic [4:0]   op;
    logic [W-1:0] a, b, lo, hi;
    logic [7:0]   lat;
  } vec_t;
  vec_t vecs[$];
  seq_alu #(.DATA_WIDTH(W)) dut (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready), .result(result), .result_hi(result_hi),
    .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic add_vec(input logic [4:0] o, input logic [W-1:0] x, y, lo, hi, input int l);
    vec_t v;
    v.op = o; v.a = x; v.b = y; v.lo = lo; v.hi = hi; v.lat = 8'(l);
    vecs.push_back(v);
  endtask
  task automatic run_op(input int idx, input vec_t v);
    int n, t0;
    string nm;
    nm = $sformatf("vec%0d op%0d", idx, v.op);
    in_valid = 1'b1; op = v.op; a = v.a; b = v.b; out_ready = 1'b1;
    #1;
    n = 0;
    while (!in_ready && n < 100) begin tick(); n++; end
    t0 = cyc;
    tick();
    in_valid = 1'b0; op = 5'($urandom); a = $urandom; b = $urandom;
    n = 0;
    while (!out_valid && n < 100) begin tick(); n++; end
    check({nm, " latency"}, cyc - t0, v.lat);
    check({nm, " result"}, {result_hi, result}, {v.hi, v.lo});
  endtask
  task automatic watch_quiet(input string name);
    int seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid) seen++;
    end
    check(name, seen, 0);
  endtask
  initial begin
    logic [W-1:0] exp;
    int mop;
`ifdef SEQ_ALU_DIV_EN
    mop = 14;
`else
    mop = 12;
`endif
    add_vec(5'd0,  32'h7FFFFFFF, 32'h1,        32'h80000000, 32'h0, 1);
    add_vec(5'd1,  32'h5,        32'h7,        32'hFFFFFFFE, 32'h0, 1);
    add_vec(5'd2,  32'hFFFFFFFF, 32'h1,        32'h1,        32'h0, 1);
    add_vec(5'd3,  32'hFFFFFFFF, 32'h1,        32'h0,        32'h0, 1);
    add_vec(5'd4,  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0, 1);
    add_vec(5'd5,  32'hF0F0F0F0, 32'h0F0F0F00, 32'h0000000F, 32'h0, 1);
    add_vec(5'd6,  32'h12340000, 32'h00005678, 32'h12345678, 32'h0, 1);
    add_vec(5'd7,  32'hFFFF0000, 32'h0F0F0F0F, 32'hF0F00F0F, 32'h0, 1);
    add_vec(5'd8,  32'h24,       32'h80000001, 32'h00000010, 32'h0, 1);
    add_vec(5'd9,  32'h4,        32'h80000000, 32'h08000000, 32'h0, 1);
    add_vec(5'd10, 32'h4,        32'h80000000, 32'hF8000000, 32'h0, 1);
    add_vec(5'd11, 32'hDEAD,     32'h00001234, 32'h12340000, 32'h0, 1);
    add_vec(5'd20, 32'h1,        32'h2,        32'hFFFFFFFF, 32'h0, 1);
    add_vec(5'd31, 32'h1,        32'h2,        32'hFFFFFFFF, 32'h0, 1);
    add_vec(5'd12, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFEB, 32'hFFFFFFFF, 34);
    add_vec(5'd13, 32'hFFFFFFFD, 32'h7,        32'hFFFFFFEB, 32'h00000006, 34);
    add_vec(5'd12, 32'h80000000, 32'h80000000, 32'h00000000, 32'h40000000, 34);
    add_vec(5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFE, 34);
    add_vec(5'd12, 32'hFFFFFFFF, 32'h5,        32'hFFFFFFFB, 32'hFFFFFFFF, 34);
`ifdef SEQ_ALU_DIV_EN
    add_vec(5'd14, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFD, 32'hFFFFFFFF, 34);
    add_vec(5'd15, 32'h7,        32'h0,        32'hFFFFFFFF, 32'h7,        1);
    add_vec(5'd14, 32'hFFFFFFFB, 32'h0,        32'hFFFFFFFF, 32'hFFFFFFFB, 1);
    add_vec(5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        34);
    add_vec(5'd15, 32'd100,      32'd5,        32'd20,       32'h0,        34);
    add_vec(5'd15, 32'hFFFFFFFF, 32'd10,       32'h19999999, 32'h5,        34);
    add_vec(5'd14, 32'h7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1,        34);
`else
    add_vec(5'd14, 32'd100,      32'd5,        32'hFFFFFFFF, 32'h0, 1);
    add_vec(5'd15, 32'h7,        32'h0,        32'hFFFFFFFF, 32'h0, 1);
`endif
    // reset
    repeat (2) tick();
    check("reset valid/busy", {out_valid, busy}, 2'b00);
    check("reset result", {result_hi, result}, 64'h0);
    resetn = 1'b1;
    #1;
    check("in_ready after reset", in_ready, 1'b1);
    // back-to-back single-cycle issue
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      op = i[0] ? 5'd7 : 5'd0;
      a = 32'h100 << i;
      b = 32'h3;
      exp = i[0] ? (a ^ b) : (a + b);
      tick();
      check($sformatf("b2b %0d", i), {out_valid, in_ready, result}, {2'b11, exp});
    end
    in_valid = 1'b0;
    tick();
    // backpressure
    out_ready = 1'b0; in_valid = 1'b1; op = 5'd0; a = 32'd1; b = 32'd2;
    tick();
    a = 32'd10; b = 32'd20;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("stall %0d", i), {out_valid, in_ready, result_hi, result}, {2'b10, 32'd0, 32'd3});
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("stall release in_ready", in_ready, 1'b1);
    tick();
    check("after stall", {out_valid, result}, {1'b1, 32'd30});
    in_valid = 1'b0;
    tick();
    // flush on the 10th iteration, with a competing request
    op = 5'(mop); a = 32'd100; b = 32'd7; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1; in_valid = 1'b1; op = 5'd0; a = 32'd1; b = 32'd1;
    #1;
    check("flush in_ready/busy", {in_ready, busy}, 2'b01);
    tick();
    flush = 1'b0;
    #1;
    check("after flush", {busy, out_valid, in_ready}, 3'b001);
    in_valid = 1'b0;
    watch_quiet("flush no result");
    // asynchronous reset mid-multiply
    op = 5'd12; a = 32'd3; b = 32'd5; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    #2 resetn = 1'b0;
    #1;
    check("async reset", {busy, out_valid, result_hi, result}, {2'b00, 64'h0});
    tick();
    resetn = 1'b1;
    #1;
    check("in_ready after mid reset", in_ready, 1'b1);
    watch_quiet("reset no result");
    // vector table
    foreach (vecs[i]) run_op(i, vecs[i]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
